// File: rtl/ga_pkg.sv
// Shared constants and types for the genetic path search stages (InitPop, selection, mutation).
package ga_pkg;

  localparam int NUM_PATHS = 50;
  localparam int PATH_BITS = 150;
  localparam int NUM_SEL   = 10;
  localparam int GRID_MAX  = 15;
  localparam int NUM_MOVES = PATH_BITS / 2;

  localparam int COORD_W = 4;
  localparam int FIT_W   = 5;
  localparam int IDX_W   = 6;

  typedef enum logic [1:0] {
    MOVE_X_INC = 2'b00,
    MOVE_Y_INC = 2'b01,
    MOVE_X_DEC = 2'b10,
    MOVE_Y_DEC = 2'b11
  } move_e;

  typedef struct packed {
    logic             valid;
    logic [FIT_W-1:0] fitness;
    logic [IDX_W-1:0] index;
  } sel_entry_t;

endpackage

// File: rtl/path_walker.sv
// Walks one path on the grid, one move per step, with coordinates saturating at the grid edges.
module path_walker
  import ga_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               step,
  input  logic [1:0]         move,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [FIT_W-1:0]   fitness
);

  localparam logic [COORD_W-1:0] MAX_C = COORD_W'(GRID_MAX);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      x <= '0;
      y <= '0;
    end else if (step) begin
      case (move_e'(move))
        MOVE_X_INC: if (x != MAX_C) x <= x + 1'b1;
        MOVE_Y_INC: if (y != MAX_C) y <= y + 1'b1;
        MOVE_X_DEC: if (x != '0)    x <= x - 1'b1;
        MOVE_Y_DEC: if (y != '0)    y <= y - 1'b1;
        default: ;
      endcase
    end
  end

  assign fitness = {1'b0, x} + {1'b0, y};

endmodule

// File: rtl/selection.sv
// Selection stage: scores every path of the population and keeps the fittest NUM_SEL in a sorted table.
module selection
  import ga_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [NUM_PATHS*PATH_BITS-1:0] population,
  output logic [NUM_SEL*PATH_BITS-1:0]   sel_population,
  output logic                           done
);

  localparam int               POP_BITS  = NUM_PATHS * PATH_BITS;
  localparam int               OFF_W     = $clog2(POP_BITS);
  localparam logic [6:0]       LAST_MOVE = 7'(NUM_MOVES - 1);
  localparam logic [IDX_W-1:0] LAST_PATH = IDX_W'(NUM_PATHS - 1);

  typedef enum logic [1:0] {S_IDLE, S_WALK, S_INSERT, S_FINISH} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   path_q;
  logic [6:0]         move_q;
  sel_entry_t         table_q [NUM_SEL];
  sel_entry_t         table_d [NUM_SEL];
  sel_entry_t         new_entry;
  int                 ins_pos;

  logic               walk_clear, walk_step;
  logic [1:0]         walk_move;
  logic [COORD_W-1:0] walk_x, walk_y;
  logic [FIT_W-1:0]   walk_fit;
  logic               walk_xy_unused;
  logic [OFF_W-1:0]   move_off;
  logic [OFF_W-1:0]   sel_off [NUM_SEL];

  assign move_off  = OFF_W'(path_q) * OFF_W'(PATH_BITS) + OFF_W'({move_q, 1'b0});
  assign walk_move = population[move_off +: 2];

  path_walker u_walker (
    .clk     (clk),
    .reset   (reset),
    .clear   (walk_clear),
    .step    (walk_step),
    .move    (walk_move),
    .x       (walk_x),
    .y       (walk_y),
    .fitness (walk_fit)
  );

  // Coordinates are only of interest when probing the walker in isolation.
  assign walk_xy_unused = ^{walk_x, walk_y};

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    walk_clear = 1'b0;
    walk_step  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_WALK;
          walk_clear = 1'b1;
        end
      end
      S_WALK: begin
        walk_step = 1'b1;
        if (move_q == LAST_MOVE) state_d = S_INSERT;
      end
      S_INSERT: begin
        walk_clear = 1'b1;
        state_d    = (path_q == LAST_PATH) ? S_FINISH : S_WALK;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // New entry lands below every valid entry of equal or higher fitness; a slot index of
  // NUM_SEL means it ranks below a full table and is dropped.
  always_comb begin
    new_entry = '{valid: 1'b1, fitness: walk_fit, index: path_q};
    ins_pos   = 0;
    for (int j = 0; j < NUM_SEL; j++) begin
      if (table_q[j].valid && (table_q[j].fitness >= walk_fit)) ins_pos = ins_pos + 1;
    end
    for (int j = 0; j < NUM_SEL; j++) begin
      if (j < ins_pos)       table_d[j] = table_q[j];
      else if (j == ins_pos) table_d[j] = new_entry;
      else                   table_d[j] = table_q[(j == 0) ? 0 : j - 1];
    end
  end

  always_comb begin
    for (int j = 0; j < NUM_SEL; j++) begin
      sel_off[j] = OFF_W'(table_q[j].index) * OFF_W'(PATH_BITS);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      path_q         <= '0;
      move_q         <= '0;
      done           <= 1'b0;
      sel_population <= '0;
      // NOTE: the table is reset explicitly, so an aborted pass can never leak stale entries.
      for (int j = 0; j < NUM_SEL; j++) table_q[j] <= '0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            path_q <= '0;
            move_q <= '0;
            for (int j = 0; j < NUM_SEL; j++) table_q[j] <= '0;
          end
        end
        S_WALK: move_q <= (move_q == LAST_MOVE) ? '0 : move_q + 1'b1;
        S_INSERT: begin
          table_q <= table_d;
          path_q  <= path_q + 1'b1;
        end
        S_FINISH: begin
          done <= 1'b1;
          for (int j = 0; j < NUM_SEL; j++) begin
            sel_population[j*PATH_BITS +: PATH_BITS] <=
              table_q[j].valid ? population[sel_off[j] +: PATH_BITS] : '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
